// File: rtl/wisc_pkg.sv
// Shared WISC-SP13 definitions: opcode encodings and the default-width scoreboard entry.
package wisc_pkg;

   localparam int OPC_W = 5;
   localparam int REG_W = 3;

   localparam logic [OPC_W-1:0] OP_HALT  = 5'b00000;
   localparam logic [OPC_W-1:0] OP_NOP   = 5'b00001;
   localparam logic [OPC_W-1:0] OP_J     = 5'b00100;
   localparam logic [OPC_W-1:0] OP_JAL   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ADDI  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_ST    = 5'b10000;
   localparam logic [OPC_W-1:0] OP_LD    = 5'b10001;
   localparam logic [OPC_W-1:0] OP_STU   = 5'b10011;
   localparam logic [OPC_W-1:0] OP_LBI   = 5'b11000;
   localparam logic [OPC_W-1:0] OP_SHIFT = 5'b11010;
   localparam logic [OPC_W-1:0] OP_ALU   = 5'b11011;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] wreg;
      logic             isLoad;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bundle between IF/ID and ID/EX; master = core, slave = scoreboard.
interface hazard_scoreboard_if #(
   parameter int OPC_W = wisc_pkg::OPC_W,
   parameter int REG_W = wisc_pkg::REG_W,
   parameter int CNT_W = 16
);
   logic                  id_valid;
   logic [OPC_W-1:0]      id_opcode;
   logic [REG_W-1:0]      id_rs;
   logic [REG_W-1:0]      id_rt;
   logic                  id_wr_en;
   logic [REG_W-1:0]      id_wr_reg;
   logic                  id_is_load;
   logic                  flush;
   logic                  freeze;
   logic                  stall;
   logic                  use_rs;
   logic                  use_rt;
   logic [2**REG_W-1:0]   pending_mask;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output id_valid, id_opcode, id_rs, id_rt, id_wr_en, id_wr_reg, id_is_load, flush, freeze,
      input  stall, use_rs, use_rt, pending_mask, stall_cnt
   );

   modport slave (
      input  id_valid, id_opcode, id_rs, id_rt, id_wr_en, id_wr_reg, id_is_load, flush, freeze,
      output stall, use_rs, use_rt, pending_mask, stall_cnt
   );
endinterface

// File: rtl/src_use_decode.sv
// Opcode -> source-register usage; one table in place of the old per-opcode match decoders.
module src_use_decode
   import wisc_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             useRs,
   output logic             useRt
);

   always_comb begin
      useRs = 1'b1;
      useRt = 1'b0;
      // Rt is read by R-format ALU/shift (1101x), set/compare ops (111xx) and the stores
      if (opcode[4:1] == OP_SHIFT[4:1] || opcode[4:2] == 3'b111 ||
          opcode == OP_ST || opcode == OP_STU)
         useRt = 1'b1;
      if (opcode <= OP_J || opcode == OP_JAL || opcode == OP_LBI)
         useRs = 1'b0;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit: shift-register scoreboard of pending writes (EX..WB) compared against
// the decode-stage sources, producing the decode stall and a saturating stall counter.
module hazard_scoreboard #(
   parameter int OPC_W       = wisc_pkg::OPC_W,
   parameter int REG_W       = wisc_pkg::REG_W,
   parameter int PIPE_DEPTH  = 3,
   parameter int FLUSH_DEPTH = 1,
   parameter int FWD_MODE    = 0,
   parameter int CNT_W       = 16
) (
   input logic clk,
   input logic rst,
   hazard_scoreboard_if.slave sb
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] wreg;
      logic             isLoad;
   } entryT;

   entryT               entry [PIPE_DEPTH];
   entryT               pushEntry;
   logic [PIPE_DEPTH-1:0] hit;
   logic                useRs;
   logic                useRt;
   logic                stall;
   logic [2**REG_W-1:0] pendingMask;
   logic [CNT_W-1:0]    stallCnt;

   src_use_decode uDecode (
      .opcode (sb.id_opcode),
      .useRs  (useRs),
      .useRt  (useRt)
   );

   // WB is compared too: the regfile has no write-through
   for (genvar i = 0; i < PIPE_DEPTH; i++) begin : gCompare
      assign hit[i] = entry[i].valid &
                      ((useRs & (entry[i].wreg == sb.id_rs)) |
                       (useRt & (entry[i].wreg == sb.id_rt)));
   end

   if (FWD_MODE == 0) begin : gStallAll
      assign stall = sb.id_valid & (|hit) & ~sb.flush;
   end else begin : gStallLoadUse
      assign stall = sb.id_valid & hit[0] & entry[0].isLoad & ~sb.flush;
   end

   always_comb begin
      pushEntry        = '0;
      pushEntry.valid  = sb.id_valid & sb.id_wr_en & ~stall & ~sb.flush;
      pushEntry.wreg   = sb.id_wr_reg;
      pushEntry.isLoad = sb.id_is_load;
   end

   // Flush is ignored while frozen; the core holds it until freeze drops
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) entry[i] <= '0;
         stallCnt <= '0;
      end else if (!sb.freeze) begin
         entry[0] <= pushEntry;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            if (sb.flush && i < FLUSH_DEPTH) entry[i] <= '0;
            else                             entry[i] <= entry[i-1];
         end
         if (stall && !(&stallCnt)) stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   always_comb begin
      pendingMask = '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
         if (entry[i].valid) pendingMask[entry[i].wreg] = 1'b1;
   end

   assign sb.stall        = stall;
   assign sb.use_rs       = useRs;
   assign sb.use_rt       = useRt;
   assign sb.pending_mask = pendingMask;
   assign sb.stall_cnt    = stallCnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: dut0 stalls on any match (16-bit counter), dut1 on load-use only (3-bit counter).
module tb_hazard_scoreboard;
   import wisc_pkg::*;

   typedef struct {
      string name;
      int    sel;
      int    es;
      int    em;
      int    ec;
      int    eur;
      int    eut;
   } expT;

   logic       clk;
   logic       rst;
   logic       idValid;
   logic [4:0] idOpcode;
   logic [2:0] idRs;
   logic [2:0] idRt;
   logic       idWrEn;
   logic [2:0] idWrReg;
   logic       idIsLoad;
   logic       flush;
   logic       freeze;

   expT expQ[$];
   expT cur;
   int  passCnt = 0;
   int  totalCnt = 0;

   hazard_scoreboard_if #(.CNT_W(16)) if0 ();
   hazard_scoreboard_if #(.CNT_W(3))  if1 ();

   assign if0.id_valid   = idValid;
   assign if0.id_opcode  = idOpcode;
   assign if0.id_rs      = idRs;
   assign if0.id_rt      = idRt;
   assign if0.id_wr_en   = idWrEn;
   assign if0.id_wr_reg  = idWrReg;
   assign if0.id_is_load = idIsLoad;
   assign if0.flush      = flush;
   assign if0.freeze     = freeze;
   assign if1.id_valid   = idValid;
   assign if1.id_opcode  = idOpcode;
   assign if1.id_rs      = idRs;
   assign if1.id_rt      = idRt;
   assign if1.id_wr_en   = idWrEn;
   assign if1.id_wr_reg  = idWrReg;
   assign if1.id_is_load = idIsLoad;
   assign if1.flush      = flush;
   assign if1.freeze     = freeze;

   hazard_scoreboard #(.FWD_MODE(0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .sb(if0.slave));
   hazard_scoreboard #(.FWD_MODE(1), .CNT_W(3))  dut1 (.clk(clk), .rst(rst), .sb(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int got, input int want);
      totalCnt++;
      if (got == want) passCnt++;
      else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
   endtask

   // Monitor: every expectation queued for this cycle is compared mid-cycle
   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         cur = expQ.pop_front();
         if (cur.es >= 0)
            check({cur.name, " stall"}, cur.sel ? int'(if1.stall) : int'(if0.stall), cur.es);
         if (cur.em >= 0)
            check({cur.name, " pending_mask"},
                  cur.sel ? int'(if1.pending_mask) : int'(if0.pending_mask), cur.em);
         if (cur.ec >= 0)
            check({cur.name, " stall_cnt"},
                  cur.sel ? int'(if1.stall_cnt) : int'(if0.stall_cnt), cur.ec);
         if (cur.eur >= 0)
            check({cur.name, " use_rs"}, cur.sel ? int'(if1.use_rs) : int'(if0.use_rs), cur.eur);
         if (cur.eut >= 0)
            check({cur.name, " use_rt"}, cur.sel ? int'(if1.use_rt) : int'(if0.use_rt), cur.eut);
      end
   end

   task automatic setIn(input bit v, input logic [4:0] op, input logic [2:0] rs,
                        input logic [2:0] rt, input bit we, input logic [2:0] wr, input bit ld);
      idValid  = v;
      idOpcode = op;
      idRs     = rs;
      idRt     = rt;
      idWrEn   = we;
      idWrReg  = wr;
      idIsLoad = ld;
   endtask

   task automatic idle();
      setIn(1'b0, OP_NOP, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic expectOn(input string nm, input int sel, input int es, input int em,
                           input int ec, input int eur, input int eut);
      expT e;
      e.name = nm; e.sel = sel; e.es = es; e.em = em; e.ec = ec; e.eur = eur; e.eut = eut;
      expQ.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string nm, input int sel, input int es, input int em, input int ec);
      expectOn(nm, sel, es, em, ec, -1, -1);
      tick();
   endtask

   task automatic cycU(input string nm, input int sel, input int es, input int em, input int ec,
                       input int eur, input int eut);
      expectOn(nm, sel, es, em, ec, eur, eut);
      tick();
   endtask

   task automatic doReset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      flush  = 1'b0;
      freeze = 1'b0;
      doReset();
      expectOn("reset dut0", 0, 0, 0, 0, -1, -1);
      cyc("reset dut1", 1, 0, 0, 0);

      // Load-use only (dut1)
      setIn(1'b1, OP_LD, 3'd1, 3'd0, 1'b1, 3'd3, 1'b1);
      cycU("ld r3 issue", 1, 0, 0, 0, 1, 0);
      setIn(1'b1, OP_ALU, 3'd3, 3'd2, 1'b1, 3'd1, 1'b0);
      cyc("load-use stall", 1, 1, 8'h08, 0);
      cyc("load-use release", 1, 0, 8'h08, 1);
      setIn(1'b1, OP_ALU, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0);
      cyc("alu r3 producer", 1, 0, 8'h0A, 1);
      setIn(1'b1, OP_ALU, 3'd3, 3'd2, 1'b1, 3'd1, 1'b0);
      cyc("alu-use forwarded", 1, 0, 8'h0A, 1);

      // Drive the 3-bit counter into saturation
      for (int k = 1; k <= 8; k++) begin
         setIn(1'b1, OP_LD, 3'd0, 3'd0, 1'b1, 3'd3, 1'b1);
         cyc("sat ld", 1, 0, -1, -1);
         setIn(1'b1, OP_ALU, 3'd3, 3'd2, 1'b1, 3'd1, 1'b0);
         cyc("sat stall", 1, 1, -1, (k < 7) ? k : 7);
         cyc("sat release", 1, 0, -1, (k + 1 < 7) ? k + 1 : 7);
      end

      doReset();
      cyc("reset2 dut0", 0, 0, 0, 0);

      // Any-match stall (dut0)
      setIn(1'b1, OP_ALU, 3'd1, 3'd2, 1'b1, 3'd3, 1'b0);
      cycU("add r3 producer", 0, 0, 0, 0, 1, 1);
      setIn(1'b1, OP_ALU, 3'd3, 3'd2, 1'b1, 3'd1, 1'b0);
      cyc("raw vs ex", 0, 1, 8'h08, 0);
      cyc("raw vs mem", 0, 1, 8'h08, 1);
      cyc("raw vs wb", 0, 1, 8'h08, 2);
      cyc("raw issues", 0, 0, 0, 3);
      idle();
      for (int k = 0; k < 3; k++) cyc("r1 in flight", 0, 0, 8'h02, 3);
      cyc("r1 retired", 0, 0, 0, 3);

      // Source-usage decode
      setIn(1'b1, OP_ADDI, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0);
      cycU("addi r5", 0, 0, 0, 3, 1, 0);
      setIn(1'b1, OP_LBI, 3'd5, 3'd5, 1'b1, 3'd2, 1'b0);
      cycU("lbi ignores rs", 0, 0, 8'h20, 3, 0, 0);
      setIn(1'b1, OP_ADDI, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0);
      cyc("addi r4", 0, 0, 8'h24, 3);
      setIn(1'b1, OP_ST, 3'd0, 3'd4, 1'b0, 3'd0, 1'b0);
      cycU("st rt hazard", 0, 1, 8'h34, 3, 1, 1);
      idle();
      cyc("drain a", 0, 0, 8'h14, 4);
      cyc("drain b", 0, 0, 8'h10, 4);
      cyc("drained", 0, 0, 0, 4);
      setIn(1'b1, OP_ADDI, 3'd6, 3'd0, 1'b1, 3'd6, 1'b0);
      cyc("self dependency", 0, 0, 0, 4);

      // Flush: decode push squashed, older entry keeps shifting
      setIn(1'b1, OP_ALU, 3'd6, 3'd0, 1'b1, 3'd7, 1'b0);
      flush = 1'b1;
      cyc("flush masks stall", 0, 0, 8'h40, 4);
      flush = 1'b0;
      idle();
      cyc("flushed push dropped", 0, 0, 8'h40, 4);
      cyc("older entry shifts", 0, 0, 8'h40, 4);
      cyc("flush drained", 0, 0, 0, 4);

      // Freeze with a pending hazard
      setIn(1'b1, OP_ADDI, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0);
      cyc("addi r1", 0, 0, 0, 4);
      setIn(1'b1, OP_ALU, 3'd1, 3'd2, 1'b1, 3'd3, 1'b0);
      freeze = 1'b1;
      for (int k = 0; k < 4; k++) cyc("frozen", 0, 1, 8'h02, 4);
      freeze = 1'b0;
      cyc("thaw ex", 0, 1, 8'h02, 4);
      cyc("thaw mem", 0, 1, 8'h02, 5);
      cyc("thaw wb", 0, 1, 8'h02, 6);
      cyc("thaw issue", 0, 0, 0, 7);

      // Reset mid-stall
      setIn(1'b1, OP_ALU, 3'd3, 3'd2, 1'b1, 3'd1, 1'b0);
      rst = 1'b1;
      cyc("pre-reset stall", 0, 1, 8'h08, 7);
      rst = 1'b0;
      expectOn("post-reset dut1", 1, 0, 0, 0, -1, -1);
      cyc("post-reset dut0", 0, 0, 0, 0);

      idle();
      tick();
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         totalCnt++;
         $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
